// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file load/dump sequencer:
// state encoding, datapath widths and the command count saturation rule.
package regfile_sequencer_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;
  localparam int RF_CNT_W  = 5;
  localparam int unsigned NUM_REGS = 32'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // A command never touches more registers than the file holds.
  function automatic int unsigned sat_count(input int unsigned count);
    return (count > NUM_REGS) ? NUM_REGS : count;
  endfunction

endpackage

// File: rtl/regfile_sequencer.sv
// Register-file initiator: bulk-loads a run of registers from an input stream
// or dumps a run of registers to an output stream through a one-entry holding register.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int CNT_W  = RF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              rf_regwrite,
  output logic [ADDR_W-1:0] rf_ra2,
  output logic [DATA_W-1:0] rf_wd,
  output logic [ADDR_W-1:0] rf_ra1,
  input  logic [DATA_W-1:0] rf_rd1,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                fetch_s;
  logic                handoff_s;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  // Next-state, counters, holding register and register-file port drive.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    rf_regwrite = 1'b0;
    rf_ra2      = '0;
    rf_wd       = '0;
    rf_ra1      = '0;
    busy        = 1'b1;
    done        = 1'b0;
    fetch_s     = 1'b0;
    handoff_s   = out_valid_q && out_ready;

    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d      = cmd_base;
          remaining_d = CNT_W'(sat_count(32'(cmd_count)));
          if (cmd_count == '0) begin
            state_d = ST_DONE;
          end else if (cmd_load) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DUMP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        // The write is suppressed during reset so an aborted load leaves no trace.
        rf_regwrite = in_valid && !reset;
        rf_ra2      = addr_q;
        rf_wd       = in_data;
        if (in_valid) begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DUMP: begin
        rf_ra1  = addr_q;
        fetch_s = (remaining_q != '0) && (!out_valid_q || out_ready);
        if (fetch_s) begin
          out_data_d  = rf_rd1;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == CNT_W'(1));
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
        end else if (handoff_s) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
        if (handoff_s && out_last_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DUMP;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a behavioural 16x16 register file plus an
// expected-contents array updated from the command rules, with randomized traffic.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_load;
  logic [3:0]  cmd_base;
  logic [4:0]  cmd_count;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [15:0] out_data;
  logic        rf_regwrite;
  logic [3:0]  rf_ra2, rf_ra1;
  logic [15:0] rf_wd, rf_rd1;
  logic        busy, done;

  logic        tb_clear;
  logic [15:0] rf_mem [16];
  int          exp_mem [16];
  int          fixed_words [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // Register file the sequencer talks to: write on clock edge, r0 reads zero.
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 16'd0;
    end else if (rf_regwrite) begin
      rf_mem[rf_ra2] <= rf_wd;
    end
  end
  assign rf_rd1 = (rf_ra1 == 4'd0) ? 16'd0 : rf_mem[rf_ra1];

  regfile_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .rf_regwrite(rf_regwrite), .rf_ra2(rf_ra2), .rf_wd(rf_wd),
    .rf_ra1(rf_ra1), .rf_rd1(rf_rd1),
    .busy(busy), .done(done)
  );

  task automatic issue_cmd(input bit load, input int base, input int count);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_load  = load;
    cmd_base  = 4'(base);
    cmd_count = 5'(count);
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL cmd_accept: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_load(input int base, input int count, input bit rand_valid);
    int eff, addr, got, cyc;
    bit v;
    logic [15:0] w;
    eff  = (count > 16) ? 16 : count;
    addr = base;
    got  = 0;
    cyc  = 0;
    issue_cmd(1'b1, base, count);
    while (got < eff && cyc < 400) begin
      v = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      w = (fixed_words.size() > 0) ? 16'(fixed_words[0]) : 16'($urandom);
      in_valid = v;
      in_data  = w;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || rf_regwrite !== v) begin
        n_err++;
        $display("FAIL load_handshake: in_ready=%b rf_regwrite=%b required 1/%b", in_ready, rf_regwrite, v);
      end
      if (v) begin
        n_cmp++;
        if (rf_ra2 !== 4'(addr) || rf_wd !== w) begin
          n_err++;
          $display("FAIL load_write: ra2=%0d wd=%h required %0d/%h", rf_ra2, rf_wd, addr, w);
        end
        exp_mem[addr] = int'(w);
        if (fixed_words.size() > 0) void'(fixed_words.pop_front());
        addr = (addr + 1) % 16;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL load_timeout: accepted %0d of %0d words", got, eff);
    end
    #1;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0 || rf_regwrite !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL load_done: done=%b busy=%b cmd_ready=%b regwrite=%b out_valid=%b required 1/1/0/0/0",
               done, busy, cmd_ready, rf_regwrite, out_valid);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_idle: done=%b busy=%b cmd_ready=%b required 0/0/1", done, busy, cmd_ready);
    end
  endtask

  // mode 0: out_ready held high, 1: random, 2: repeating 1,0,0,1,1
  task automatic run_dump(input int base, input int count, input int mode);
    int eff, idx, k, a;
    int q[$];
    int pat[5] = '{1, 0, 0, 1, 1};
    bit r, prev_valid, prev_ready, prev_last;
    logic [15:0] prev_data;
    eff = (count > 16) ? 16 : count;
    for (int i = 0; i < eff; i++) begin
      a = (base + i) % 16;
      q.push_back((a == 0) ? 0 : exp_mem[a]);
    end
    issue_cmd(1'b0, base, count);
    idx = 0;
    k = 1;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_last  = 1'b0;
    prev_data  = 16'd0;
    while (idx < eff && k < 400) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'(pat[(k - 1) % 5]);
      out_ready = r;
      #1;
      if (k == 1) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL dump_latency1: out_valid=%b required 0", out_valid);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL dump_latency2: out_valid=%b required 1", out_valid);
        end
      end
      if (prev_valid && !prev_ready) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          n_err++;
          $display("FAIL dump_stall_hold: valid=%b data=%h last=%b required 1/%h/%b",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid) begin
        n_cmp++;
        if (out_data !== 16'(q[idx]) || out_last !== 1'(idx == eff - 1) || busy !== 1'b1) begin
          n_err++;
          $display("FAIL dump_word: idx=%0d data=%h last=%b busy=%b required %h/%b/1",
                   idx, out_data, out_last, busy, 16'(q[idx]), idx == eff - 1);
        end
      end
      prev_valid = out_valid;
      prev_ready = r;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid && r) idx++;
      @(negedge clk);
      k++;
    end
    out_ready = 1'b0;
    if (k >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL dump_timeout: handed off %0d of %0d words", idx, eff);
    end
    #1;
    n_cmp++;
    if (done !== 1'b1 || out_valid !== 1'b0 || cmd_ready !== 1'b0 || rf_regwrite !== 1'b0) begin
      n_err++;
      $display("FAIL dump_done: done=%b out_valid=%b cmd_ready=%b regwrite=%b required 1/0/0/0",
               done, out_valid, cmd_ready, rf_regwrite);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL dump_idle: done=%b busy=%b cmd_ready=%b required 0/0/1", done, busy, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tb_clear = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tb_clear = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 ||
        out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 16'd0 || rf_regwrite !== 1'b0 ||
        rf_ra1 !== 4'd0 || rf_ra2 !== 4'd0 || rf_wd !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b busy=%b done=%b in_rdy=%b ov=%b ol=%b od=%h we=%b ra1=%0d ra2=%0d wd=%h",
               cmd_ready, busy, done, in_ready, out_valid, out_last, out_data, rf_regwrite, rf_ra1, rf_ra2, rf_wd);
    end
  endtask

  task automatic test_load_dump_basic();
    fixed_words = '{32'h00AA, 32'h00BB, 32'h00CC};
    run_load(1, 3, 1'b0);
    run_dump(1, 3, 2);
  endtask

  task automatic test_wrap();
    fixed_words = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_load(14, 4, 1'b0);
    run_dump(14, 4, 0);
  endtask

  task automatic test_count_limits();
    run_load(7, 0, 1'b0);
    run_dump(3, 0, 0);
    run_load(9, 20, 1'b1);
    run_dump(2, 20, 1);
  endtask

  task automatic test_reset_in_load();
    logic [15:0] w;
    issue_cmd(1'b1, 5, 5);
    for (int i = 0; i < 2; i++) begin
      w = 16'($urandom);
      in_valid = 1'b1;
      in_data  = w;
      #1;
      exp_mem[5 + i] = int'(w);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    reset    = 1'b1;
    #1;
    n_cmp++;
    if (rf_regwrite !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_write: rf_regwrite=%b required 0", rf_regwrite);
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_load_idle: busy=%b in_ready=%b cmd_ready=%b done=%b required 0/0/1/0",
               busy, in_ready, cmd_ready, done);
    end
    run_dump(5, 5, 0);
  endtask

  task automatic test_reset_in_dump();
    issue_cmd(1'b0, 1, 3);
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_setup: out_valid=%b required 1", out_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dump_idle: out_valid=%b out_last=%b done=%b busy=%b required 0/0/0/0",
               out_valid, out_last, done, busy);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dump_nodone: done=%b out_valid=%b required 0/0", done, out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 1) == 1)
        run_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 20)), 1'b1);
      else
        run_dump(int'($urandom_range(0, 15)), int'($urandom_range(0, 20)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    reset = 1'b1;
    tb_clear = 1'b1;
    cmd_valid = 1'b0;
    cmd_load = 1'b0;
    cmd_base = 4'd0;
    cmd_count = 5'd0;
    in_valid = 1'b0;
    in_data = 16'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 0;
    test_reset();
    test_load_dump_basic();
    test_wrap();
    test_count_limits();
    test_reset_in_load();
    test_reset_in_dump();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
